// File: rtl/paralelo_serial_pkg.sv
// ps_pkg: shared defaults and FSM state type for the parallel-to-serial transmitter
package ps_pkg;
  localparam logic [7:0] COMMA_DEF = 8'hBC;
  localparam int N_TRAIN_DEF = 4;
  typedef enum logic {ST_TRAIN = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/paralelo_serial_if.sv
// paralelo_serial_if: byte handshake and serial output bundle
interface paralelo_serial_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       byte_start;
  logic       active_out;
  modport master (output data_in, valid_in, input ready_out, data_out, byte_start, active_out);
  modport slave (input data_in, valid_in, output ready_out, data_out, byte_start, active_out);
endinterface

// File: rtl/paralelo_serial_hold_reg.sv
// ps_hold_reg: one-byte holding register between the handshake and the shifter
module ps_hold_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       drain_i,
  output logic       ready_o,
  output logic       full_o,
  output logic [7:0] hold_data_o
);
  logic       full_q, full_d, load;
  logic [7:0] data_q, data_d;
  assign ready_o     = run_i && !full_q;
  assign load        = valid_i && ready_o;
  assign full_o      = full_q;
  assign hold_data_o = data_q;
  // drain and load are mutually exclusive: ready is low whenever the register is full
  always_comb begin
    full_d = load ? 1'b1 : (drain_i ? 1'b0 : full_q);
    data_d = load ? data_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/paralelo_serial.sv
// paralelo_serial: MSB-first byte serializer with comma training and comma idle fill
module paralelo_serial
  import ps_pkg::*;
#(
  parameter logic [7:0] COMMA   = COMMA_DEF,
  parameter int         N_TRAIN = N_TRAIN_DEF
) (
  input logic clk_32f,
  input logic reset,
  paralelo_serial_if.slave bus
);
  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] train_cnt_q;
  logic [7:0] shift_q, hold_data;
  logic       hold_full, ready, load, drain;
  assign load  = bit_cnt_q == 3'd7;
  assign drain = load && state_q == ST_RUN && hold_full;
  ps_hold_reg u_hold (
    .clk        (clk_32f),
    .rst        (reset),
    .run_i      (state_q == ST_RUN),
    .data_i     (bus.data_in),
    .valid_i    (bus.valid_in),
    .drain_i    (drain),
    .ready_o    (ready),
    .full_o     (hold_full),
    .hold_data_o(hold_data)
  );
  // bit_cnt resets to 7 so the first edge after release loads a comma
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= ST_TRAIN;
      bit_cnt_q   <= 3'd7;
      train_cnt_q <= 4'd0;
      shift_q     <= 8'h00;
    end else begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      shift_q   <= load ? (drain ? hold_data : COMMA) : {shift_q[6:0], 1'b0};
      if (load && state_q == ST_TRAIN) begin
        train_cnt_q <= train_cnt_q + 4'd1;
        if (train_cnt_q == 4'(N_TRAIN - 1)) state_q <= ST_RUN;
      end
    end
  end
  assign bus.data_out   = shift_q[7];
  assign bus.byte_start = bit_cnt_q == 3'd0;
  assign bus.ready_out  = ready;
  assign bus.active_out = state_q == ST_RUN;
endmodule

// File: tb/tb_paralelo_serial.sv
// tb_paralelo_serial: directed + random stimulus against a slot-level reference model
module tb_paralelo_serial;
  localparam logic [7:0] COMMA   = 8'hBC;
  localparam int         N_TRAIN = 4;
  logic clk_32f = 1'b0;
  logic reset   = 1'b1;
  paralelo_serial_if bus ();
  paralelo_serial dut (.clk_32f(clk_32f), .reset(reset), .bus(bus.slave));
  always #5 clk_32f = ~clk_32f;
  int n_cmp = 0, n_bad = 0;
  // model: m_t counts edges since release; a symbol slot starts at edges 1, 9, 17, ...
  int         m_t = 0, m_trained = 0;
  logic       m_run = 1'b0, m_pend = 1'b0, m_acc = 1'b0;
  logic [7:0] m_byte = 8'h00, m_sym = 8'h00;
  logic [7:0] stream [3] = '{8'hEE, 8'hBC, 8'h5A};
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    reset = r;
    bus.valid_in = v;
    bus.data_in = d;
    @(posedge clk_32f);
    m_acc = 1'b0;
    if (r) begin
      m_t = 0; m_trained = 0; m_run = 1'b0; m_pend = 1'b0; m_sym = 8'h00;
    end else begin
      m_acc = v && m_run && !m_pend;
      m_t++;
      if (m_t % 8 == 1) begin
        m_sym = (m_run && m_pend) ? m_byte : COMMA;
        m_pend = 1'b0;
        if (!m_run) begin
          m_trained++;
          if (m_trained == N_TRAIN) m_run = 1'b1;
        end
      end
      if (m_acc) begin
        m_pend = 1'b1;
        m_byte = d;
      end
    end
    #1;
    chk("data_out", {7'd0, bus.data_out}, (m_t == 0) ? 8'd0 : {7'd0, m_sym[3'(7 - (m_t - 1) % 8)]});
    chk("byte_start", {7'd0, bus.byte_start}, {7'd0, m_t % 8 == 1});
    chk("ready_out", {7'd0, bus.ready_out}, {7'd0, m_run && !m_pend});
    chk("active_out", {7'd0, bus.active_out}, {7'd0, m_run});
  endtask
  initial begin
    int idx, guard;
    bus.valid_in = 1'b0;
    bus.data_in = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 25; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 27; i <= 48; i++) step(1'b0, 1'b0, 8'h00);
    idx = 0;
    guard = 0;
    while (idx < 3 && guard < 64) begin
      step(1'b0, 1'b1, stream[idx]);
      if (m_acc) idx++;
      guard++;
    end
    if (idx < 3) chk("stream_timeout", 8'(idx), 8'd3);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 200; i++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    guard = 0;
    while (m_t % 8 != 2 && guard < 16) begin
      step(1'b0, 1'b0, 8'h00);
      guard++;
    end
    step(1'b0, 1'b1, 8'h77);
    chk("pending_before_reset", {7'd0, bus.ready_out}, 8'd0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 2; i <= 20; i++) step(1'b0, 1'b1, 8'h12);
    for (int i = 21; i <= 40; i++) step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 150; i++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
